// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - multi-account ATM session controller
// PIN login with per-account lockout, then balance/withdraw/deposit/PIN-change until logout or timeout.
module atm_session_ctrl #(
  parameter int NUM_ACC   = 10,
  parameter int ACC_W     = 4,
  parameter int PIN_W     = 16,
  parameter int BAL_W     = 32,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1000,
  parameter int BAL_STEP  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [2:0]       operation,
  input  logic [BAL_W-1:0] amount,
  input  logic [PIN_W-1:0] new_pin,
  output logic [BAL_W-1:0] balance,
  output logic             success,
  output logic             done,
  output logic [2:0]       err,
  output logic [2:0]       state,
  output logic             session
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MENU  = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] E_NONE = 3'd0, E_BAD_ACC = 3'd1, E_BAD_PIN = 3'd2, E_LOCKED = 3'd3;
  localparam logic [2:0] E_NO_FUNDS = 3'd4, E_OVERFLOW = 3'd5, E_BAD_OP = 3'd6, E_TIMEOUT = 3'd7;
  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [PIN_W-1:0]   pin_q, npin_q;
  logic [2:0]         op_q;
  logic [BAL_W-1:0]   amt_q;
  logic [BAL_W-1:0]   bal_db [NUM_ACC];
  logic [PIN_W-1:0]   pin_db [NUM_ACC];
  logic [CNT_W-1:0]   fail_cnt [NUM_ACC];
  logic               locked [NUM_ACC];
  logic [TO_W-1:0]    to_cnt, to_d;
  logic               alive_q, alive_d;
  logic               succ_q, succ_d;
  logic [2:0]         err_q, err_d;
  logic [BAL_W-1:0]   bal_q, bal_d;

  logic               acc_ok;
  logic [BAL_W-1:0]   cur_bal;
  logic [PIN_W-1:0]   cur_pin;
  logic [CNT_W-1:0]   cur_fail;
  logic               cur_lock;
  logic [BAL_W:0]     sum;
  logic               latch_login, latch_op, wr_bal, wr_pin, fail_inc, fail_clr, set_lock;
  logic [BAL_W-1:0]   new_bal;

  assign acc_ok   = ({{(32-ACC_W){1'b0}}, acc_q} < NUM_ACC);
  assign cur_bal  = acc_ok ? bal_db[acc_q]   : '0;
  assign cur_pin  = acc_ok ? pin_db[acc_q]   : '0;
  assign cur_fail = acc_ok ? fail_cnt[acc_q] : '0;
  assign cur_lock = acc_ok ? locked[acc_q]   : 1'b0;
  assign sum      = {1'b0, cur_bal} + {1'b0, amt_q};

  always_comb begin
    state_d     = state_q;
    succ_d      = succ_q;
    err_d       = err_q;
    bal_d       = bal_q;
    alive_d     = alive_q;
    to_d        = to_cnt;
    latch_login = 1'b0;
    latch_op    = 1'b0;
    wr_bal      = 1'b0;
    wr_pin      = 1'b0;
    new_bal     = cur_bal;
    fail_inc    = 1'b0;
    fail_clr    = 1'b0;
    set_lock    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_login = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
        succ_d  = 1'b0;
        alive_d = 1'b0;
        if (!acc_ok) begin
          err_d = E_BAD_ACC;
        end else if (cur_lock) begin
          err_d = E_LOCKED;
        end else if (pin_q != cur_pin) begin
          err_d = E_BAD_PIN;
          // counter saturates; the lock latches on the attempt that reaches the limit
          if (cur_fail < CNT_W'(MAX_TRIES)) fail_inc = 1'b1;
          if (cur_fail + CNT_W'(1) >= CNT_W'(MAX_TRIES)) set_lock = 1'b1;
        end else begin
          err_d    = E_NONE;
          succ_d   = 1'b1;
          alive_d  = 1'b1;
          fail_clr = 1'b1;
          bal_d    = cur_bal;
        end
      end
      S_MENU: begin
        if (op_valid) begin
          latch_op = 1'b1;
          to_d     = '0;
          state_d  = S_EXEC;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          to_d    = '0;
          succ_d  = 1'b0;
          err_d   = E_TIMEOUT;
          alive_d = 1'b0;
          state_d = S_DONE;
        end else begin
          to_d = to_cnt + TO_W'(1);
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        succ_d  = 1'b1;
        err_d   = E_NONE;
        bal_d   = cur_bal;
        case (op_q)
          3'd0: ;
          3'd1: begin
            if (amt_q > cur_bal) begin
              succ_d = 1'b0;
              err_d  = E_NO_FUNDS;
            end else begin
              wr_bal  = 1'b1;
              new_bal = cur_bal - amt_q;
              bal_d   = new_bal;
            end
          end
          3'd2: begin
            if (sum[BAL_W]) begin
              succ_d = 1'b0;
              err_d  = E_OVERFLOW;
            end else begin
              wr_bal  = 1'b1;
              new_bal = sum[BAL_W-1:0];
              bal_d   = new_bal;
            end
          end
          3'd3: wr_pin = 1'b1;
          3'd4: alive_d = 1'b0;
          default: begin
            succ_d = 1'b0;
            err_d  = E_BAD_OP;
          end
        endcase
      end
      S_DONE: state_d = alive_q ? S_MENU : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      pin_q   <= '0;
      npin_q  <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      to_cnt  <= '0;
      alive_q <= 1'b0;
      succ_q  <= 1'b0;
      err_q   <= E_NONE;
      bal_q   <= '0;
      for (int i = 0; i < NUM_ACC; i++) begin
        bal_db[i]   <= BAL_W'((i + 1) * BAL_STEP);
        pin_db[i]   <= PIN_W'(i);
        fail_cnt[i] <= '0;
        locked[i]   <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      to_cnt  <= to_d;
      alive_q <= alive_d;
      succ_q  <= succ_d;
      err_q   <= err_d;
      bal_q   <= bal_d;
      if (latch_login) begin
        acc_q <= acc_num;
        pin_q <= pin;
      end
      if (latch_op) begin
        op_q   <= operation;
        amt_q  <= amount;
        npin_q <= new_pin;
      end
      if (wr_bal)   bal_db[acc_q]   <= new_bal;
      if (wr_pin)   pin_db[acc_q]   <= npin_q;
      if (fail_inc) fail_cnt[acc_q] <= cur_fail + CNT_W'(1);
      if (fail_clr) fail_cnt[acc_q] <= '0;
      if (set_lock) locked[acc_q]   <= 1'b1;
    end
  end

  assign state   = state_q;
  assign done    = (state_q == S_DONE);
  assign success = succ_q;
  assign err     = err_q;
  assign balance = bal_q;
  assign session = (state_q == S_MENU) || (state_q == S_EXEC) || ((state_q == S_DONE) && alive_q);

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised multi-account ATM session controller; successor to the single-shot ATM state machine. Authenticates an account by PIN, then holds a session open for any number of balance, withdraw, deposit and PIN-change operations until the user logs out or the session times out. Adds per-account wrong-PIN lockout, overflow and insufficient-funds checks, and a done/error handshake. Sits between the front-panel input logic and the display/dispenser logic.

## Interface
- NUM_ACC, default 10: number of accounts, indices 0..NUM_ACC-1.
- ACC_W, default 4: account-number width; must satisfy 2^ACC_W >= NUM_ACC.
- PIN_W, default 16: PIN width.
- BAL_W, default 32: balance and amount width, unsigned.
- MAX_TRIES, default 3: consecutive wrong PINs before the account locks.
- TIMEOUT, default 1000: idle cycles in MENU before forced logout.
- BAL_STEP, default 1000: reset balance of account i is (i+1)*BAL_STEP.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  login request; sampled only in IDLE.
- acc_num  in  ACC_W  account index for login.
- pin  in  PIN_W  PIN for login.
- op_valid  in  1  operation request; sampled only in MENU.
- operation  in  3  0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 CHANGE_PIN, 4 LOGOUT, 5-7 illegal.
- amount  in  BAL_W  withdraw/deposit amount.
- new_pin  in  PIN_W  replacement PIN.
- balance  out  BAL_W  balance of the session account; updated in DONE.
- success  out  1  result of the last request; valid while done=1.
- done  out  1  one-cycle completion pulse.
- err  out  3  0 NONE, 1 BAD_ACC, 2 BAD_PIN, 3 LOCKED, 4 NO_FUNDS, 5 OVERFLOW, 6 BAD_OP, 7 TIMEOUT.
- state  out  3  current FSM state encoding.
- session  out  1  high while in MENU, EXEC or DONE-with-session.

## Operation
- States: IDLE=0, CHECK=1, MENU=2, EXEC=3, DONE=4.
- Reset: state IDLE, all outputs 0, balance[i]=(i+1)*BAL_STEP, pin_db[i]=i (zero-extended), fail counters 0, lock flags 0, timeout counter 0.
- IDLE: on start=1, latch acc_num and pin, go to CHECK. Otherwise stay.
- CHECK (1 cycle):
  - acc_num >= NUM_ACC: err BAD_ACC.
  - Account locked: err LOCKED; the PIN is not compared.
  - PIN mismatch: increment the fail counter; when it reaches MAX_TRIES, set the lock flag; err BAD_PIN.
  - On any of the above, go to DONE with success=0 and no session.
  - PIN match: clear the fail counter; success=1, err NONE; go to DONE with session.
- MENU: the timeout counter increments each cycle.
  - op_valid=1: latch operation, amount and new_pin, clear the counter, go to EXEC.
  - Counter reaches TIMEOUT-1 with no op_valid: err TIMEOUT, success=0, session ends, go to DONE.
- EXEC (1 cycle), on the session account:
  - BALANCE: always succeeds.
  - WITHDRAW: amount > balance gives NO_FUNDS with the balance unchanged; otherwise balance -= amount.
  - DEPOSIT: sum computed in BAL_W+1 bits; a carry gives OVERFLOW with the balance unchanged; otherwise balance += amount.
  - CHANGE_PIN: pin_db = new_pin.
  - LOGOUT: succeeds and ends the session.
  - Illegal codes: BAD_OP, success=0, session kept.
  - Then go to DONE.
- DONE (1 cycle): done=1, success and err valid, balance output = current session-account balance. Next state is MENU if the session is alive, else IDLE.
- Lock flags clear only on rst. The fail counter saturates at MAX_TRIES.
- amount=0 on WITHDRAW or DEPOSIT succeeds with no change.

## Timing
- Login: start at edge N; CHECK at N+1; DONE (done=1) at N+2; MENU or IDLE at N+3.
- Operation: op_valid in MENU at edge M; EXEC at M+1; DONE at M+2; database updated at the M+2 edge; back in MENU at M+3.
- start outside IDLE and op_valid outside MENU are ignored; no queueing.
- success and err hold their values until the next DONE; done is high only in DONE.
- rst asserted in any state, including mid-EXEC: next edge forces the full reset state; a pending update is discarded.
- Timeout: exactly TIMEOUT cycles in MENU without op_valid ends the session.

## Test plan
- Reset, login account 2 with pin 2 -> done at the 2nd edge after start, success=1, session=1; BALANCE -> balance=3000.
- WITHDRAW 500 from account 0 -> balance=500; WITHDRAW 600 -> err NO_FUNDS, balance stays 500.
- BAL_W=16, account 9 (10000), DEPOSIT 60000 -> err OVERFLOW, balance 10000; DEPOSIT 5535 -> 15535.
- Three wrong PINs on account 4 -> err BAD_PIN x3; 4th attempt with pin 4 -> err LOCKED; after rst, pin 4 -> success.
- CHANGE_PIN to 16'h1234, LOGOUT -> IDLE; login with old pin -> BAD_PIN; login with 16'h1234 -> success.
- TIMEOUT=8, login, no op_valid for 8 cycles -> err TIMEOUT, session=0, IDLE; rst mid-EXEC of WITHDRAW -> balance restored to reset value.
